// File: rtl/lsu_wide.sv
// Load/store unit: splits one CPU access into Wishbone pipelined beats,
// gathers and extends load data, and pulses register write-back.
module lsu_wide #(
   parameter int XLEN = 64,
   parameter int BUSW = 16
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              valid_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   input  logic              nomem_i,
   input  logic [XLEN-1:0]   wdat_i,
   output logic              busy_o,
   output logic              rwe_o,
   output logic [XLEN-1:0]   rdat_o,
   output logic              misalign_o,
   output logic              fault_o,
   output logic [XLEN-1:0]   wbmadr_o,
   output logic [BUSW-1:0]   wbmdat_o,
   output logic [BUSW/8-1:0] wbmsel_o,
   output logic              wbmwe_o,
   output logic              wbmstb_o,
   output logic              wbmcyc_o,
   input  logic              wbmstall_i,
   input  logic              wbmack_i,
   input  logic              wbmerr_i,
   input  logic [BUSW-1:0]   wbmdat_i
);

   localparam int BB = BUSW / 8;
   localparam int LB = $clog2(BB);
   localparam logic [XLEN-1:0] BMX = XLEN'({BUSW{1'b1}});

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_n;

   logic [XLEN-1:0] addr_q, wdat_q, dbuf, merged, rdat_q;
   logic            we_q, sgn_q, err_q, pass_q, mis_q;
   logic [1:0]      size_q;
   logic [3:0]      icnt, acnt, icnt_n, acnt_n, nbeat, bytes, amask;
   logic            sub, stb, cyc, take, term, errnow, mis_c;
   logic [LB-1:0]   off;
   logic [BB-1:0]   lmask, selc;
   logic [BUSW-1:0] bmask, wlane;

   function automatic logic [XLEN-1:0] ext(
      input logic [XLEN-1:0] d,
      input logic [1:0]      sz,
      input logic            s
   );
      case (sz)
         2'd0:    ext = {{(XLEN-8){s & d[7]}}, d[7:0]};
         2'd1:    ext = {{(XLEN-16){s & d[15]}}, d[15:0]};
         2'd2:    ext = {{(XLEN-32){s & d[31]}}, d[31:0]};
         default: ext = d;
      endcase
   endfunction

   assign amask = (4'd1 << size_i) - 4'd1;
   assign mis_c = |(addr_i[2:0] & amask[2:0]);

   assign bytes = 4'd1 << size_q;
   assign sub   = int'(bytes) < BB;
   assign nbeat = sub ? 4'd1 : 4'(int'(bytes) / BB);
   assign off   = addr_q[LB-1:0];
   assign lmask = BB'((9'd1 << bytes) - 9'd1);
   assign selc  = sub ? (lmask << off) : '1;

   always_comb begin
      bmask = '0;
      for (int b = 0; b < BB; b++)
         bmask[b*8 +: 8] = {8{selc[b]}};
   end

   // Sub-bus stores sit in their byte lanes; full beats slice the word.
   always_comb begin
      wlane = BUSW'(wdat_q >> (int'(icnt) * BUSW));
      if (sub)
         wlane = (BUSW'(wdat_q) << {off, 3'b000}) & bmask;
   end

   assign stb    = state == ISSUE;
   assign cyc    = state == ISSUE || state == WAIT;
   assign take   = stb & ~wbmstall_i;
   assign term   = cyc & (wbmack_i | wbmerr_i) & (acnt != icnt);
   assign icnt_n = icnt + 4'(take);
   assign acnt_n = acnt + 4'(term);
   assign errnow = err_q | (term & wbmerr_i);

   always_comb begin
      merged = dbuf;
      if (term && wbmack_i && !wbmerr_i) begin
         if (sub)
            merged = XLEN'(wbmdat_i >> {off, 3'b000});
         else
            merged = (dbuf & ~(BMX << (int'(acnt) * BUSW)))
                   | (XLEN'(wbmdat_i) << (int'(acnt) * BUSW));
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (valid_i && !nomem_i && !mis_c)
               state_n = ISSUE;
         ISSUE:
            if (errnow)
               state_n = (acnt_n == icnt_n) ? DONE : WAIT;
            else if (acnt_n == nbeat)
               state_n = DONE;
            else if (icnt_n == nbeat)
               state_n = WAIT;
         WAIT:
            if (errnow && acnt_n == icnt_n)
               state_n = DONE;
            else if (!errnow && acnt_n == nbeat)
               state_n = DONE;
         default:
            state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state  <= IDLE;
         addr_q <= '0;
         wdat_q <= '0;
         we_q   <= 1'b0;
         sgn_q  <= 1'b0;
         size_q <= '0;
         icnt   <= '0;
         acnt   <= '0;
         err_q  <= 1'b0;
         dbuf   <= '0;
         rdat_q <= '0;
         pass_q <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         state  <= state_n;
         pass_q <= 1'b0;
         mis_q  <= 1'b0;
         if (state == IDLE && valid_i) begin
            if (nomem_i) begin
               pass_q <= 1'b1;
               rdat_q <= addr_i;
            end else if (mis_c) begin
               mis_q <= 1'b1;
            end else begin
               addr_q <= addr_i;
               wdat_q <= wdat_i;
               we_q   <= we_i;
               sgn_q  <= signed_i;
               size_q <= size_i;
               icnt   <= '0;
               acnt   <= '0;
               err_q  <= 1'b0;
               dbuf   <= '0;
            end
         end else if (cyc) begin
            icnt <= icnt_n;
            acnt <= acnt_n;
            dbuf <= merged;
            if (term && wbmerr_i)
               err_q <= 1'b1;
            if (state_n == DONE && !we_q && !errnow)
               rdat_q <= ext(merged, size_q, sgn_q);
         end
      end
   end

   assign busy_o     = state != IDLE;
   assign rwe_o      = pass_q | (state == DONE & ~we_q & ~err_q);
   assign fault_o    = state == DONE & err_q;
   assign misalign_o = mis_q;
   assign rdat_o     = rdat_q;
   assign wbmcyc_o   = cyc;
   assign wbmstb_o   = stb;
   assign wbmwe_o    = stb & we_q;
   assign wbmsel_o   = stb ? selc : '0;
   assign wbmdat_o   = (stb && we_q) ? wlane : '0;
   assign wbmadr_o   = stb ? (addr_q & ~XLEN'(BB - 1))
                           + XLEN'(int'(icnt) * BB) : '0;

endmodule

// File: tb/tb_lsu_wide.sv
// Directed bench for lsu_wide: a 16-bit bus instance and a 32-bit
// bus instance, each with a small Wishbone slave model.
module tb_lsu_wide;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        valid_a, valid_b;
   logic [63:0] addr, wdat;
   logic        we, sgn, nomem;
   logic [1:0]  size;

   logic        busy_a, rwe_a, mis_a, fault_a, we_a, stb_a, cyc_a;
   logic [63:0] rdat_a, adr_a;
   logic [15:0] dat_a, rd_a;
   logic [1:0]  sel_a;
   logic        stall_a, ack_a, err_a;

   logic        busy_b, rwe_b, mis_b, fault_b, we_b, stb_b, cyc_b;
   logic [63:0] rdat_b, adr_b;
   logic [31:0] dat_b;
   logic [3:0]  sel_b;
   logic        stall_b, ack_b;

   lsu_wide #(.XLEN(64), .BUSW(16)) u_a (
      .clk_i(clk), .reset_ni(rst_n), .valid_i(valid_a),
      .addr_i(addr), .we_i(we), .size_i(size), .signed_i(sgn),
      .nomem_i(nomem), .wdat_i(wdat), .busy_o(busy_a),
      .rwe_o(rwe_a), .rdat_o(rdat_a), .misalign_o(mis_a),
      .fault_o(fault_a), .wbmadr_o(adr_a), .wbmdat_o(dat_a),
      .wbmsel_o(sel_a), .wbmwe_o(we_a), .wbmstb_o(stb_a),
      .wbmcyc_o(cyc_a), .wbmstall_i(stall_a), .wbmack_i(ack_a),
      .wbmerr_i(err_a), .wbmdat_i(rd_a)
   );

   lsu_wide #(.XLEN(64), .BUSW(32)) u_b (
      .clk_i(clk), .reset_ni(rst_n), .valid_i(valid_b),
      .addr_i(addr), .we_i(we), .size_i(size), .signed_i(sgn),
      .nomem_i(nomem), .wdat_i(wdat), .busy_o(busy_b),
      .rwe_o(rwe_b), .rdat_o(rdat_b), .misalign_o(mis_b),
      .fault_o(fault_b), .wbmadr_o(adr_b), .wbmdat_o(dat_b),
      .wbmsel_o(sel_b), .wbmwe_o(we_b), .wbmstb_o(stb_b),
      .wbmcyc_o(cyc_b), .wbmstall_i(stall_b), .wbmack_i(ack_b),
      .wbmerr_i(1'b0), .wbmdat_i(32'h0)
   );

   // Slave A: ack next cycle; stalls once the error beat was taken.
   logic        err_en, seen, use_fix;
   logic [63:0] err_adr;
   logic [15:0] fix;
   assign stall_a = err_en & seen;
   always @(posedge clk) begin
      ack_a <= 1'b0;
      err_a <= 1'b0;
      if (stb_a && !stall_a) begin
         if (err_en && adr_a == err_adr) err_a <= 1'b1;
         else ack_a <= 1'b1;
         rd_a <= use_fix ? fix : adr_a[15:0] + 16'h8000;
      end
      if (!err_en) seen <= 1'b0;
      else if (stb_a && !stall_a && adr_a == err_adr) seen <= 1'b1;
   end

   // Slave B: stalls the first stall_req strobe cycles.
   logic [3:0] scnt, stall_req;
   assign stall_b = stb_b && (scnt < stall_req);
   always @(posedge clk) begin
      scnt  <= stb_b ? scnt + 4'd1 : 4'd0;
      ack_b <= stb_b && !stall_b;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   int          nb, stbc, rwec, rwei, lastack, faultc, misc, cycc, busyc;
   logic [63:0] adrs [8];
   logic [3:0]  sel0;
   logic [31:0] dat0;
   logic        we0;

   task automatic issue(input logic [63:0] a, input logic w,
                        input logic [1:0] s, input logic sg,
                        input logic nm, input logic [63:0] wd,
                        input logic on_b);
      @(negedge clk);
      addr = a; we = w; size = s; sgn = sg; nomem = nm; wdat = wd;
      valid_a = !on_b;
      valid_b = on_b;
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      addr = '1; wdat = '1; we = !w; size = ~s;
      nb = 0; stbc = 0; rwec = 0; rwei = -1; lastack = -1;
      faultc = 0; misc = 0; cycc = 0; busyc = 0;
      sel0 = '0; dat0 = '0; we0 = 1'b0;
   endtask

   task automatic watch_a();
      for (int i = 0; i < 20; i++) begin
         if (stb_a && !stall_a && nb < 8) begin
            adrs[nb] = adr_a;
            nb++;
         end
         if (stb_a && stbc == 0) sel0 = {2'b00, sel_a};
         if (stb_a) stbc++;
         if (ack_a || err_a) lastack = i;
         if (rwe_a) begin rwec++; rwei = i; end
         faultc += int'(fault_a);
         misc   += int'(mis_a);
         cycc   += int'(cyc_a);
         busyc  += int'(busy_a);
         @(negedge clk);
      end
   endtask

   task automatic watch_b();
      for (int i = 0; i < 20; i++) begin
         if (stb_b && stbc == 0) begin
            sel0 = sel_b; dat0 = dat_b; we0 = we_b; adrs[0] = adr_b;
         end
         if (stb_b) stbc++;
         if (rwe_b) rwec++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic found;
      rst_n = 1'b0;
      valid_a = 1'b0; valid_b = 1'b0;
      addr = '0; wdat = '0; we = 1'b0; size = '0;
      sgn = 1'b0; nomem = 1'b0;
      err_en = 1'b0; err_adr = '0; use_fix = 1'b0; fix = '0;
      stall_req = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_a, 0);
      chk("rst_rdat", rdat_a, 0);
      chk("rst_cyc", cyc_a, 0);
      chk("rst_rwe", rwe_b, 0);
      rst_n = 1'b1;

      issue(64'h1000, 0, 3, 1, 0, 0, 0);
      watch_a();
      chk("dw_beats", 64'(nb), 4);
      chk("dw_adr0", adrs[0], 64'h1000);
      chk("dw_adr1", adrs[1], 64'h1002);
      chk("dw_adr2", adrs[2], 64'h1004);
      chk("dw_adr3", adrs[3], 64'h1006);
      chk("dw_rdat", rdat_a, 64'h9006_9004_9002_9000);
      chk("dw_rwe_n", 64'(rwec), 1);
      chk("dw_rwe_lat", 64'(rwei - lastack), 1);
      chk("dw_idle", busy_a, 0);

      use_fix = 1'b1; fix = 16'h8000;
      issue(64'h1001, 0, 0, 1, 0, 0, 0);
      watch_a();
      chk("bs_sel", 64'(sel0), 64'h2);
      chk("bs_beats", 64'(nb), 1);
      chk("bs_rdat", rdat_a, 64'hFFFF_FFFF_FFFF_FF80);
      issue(64'h1001, 0, 0, 0, 0, 0, 0);
      watch_a();
      chk("bu_rdat", rdat_a, 64'h80);
      use_fix = 1'b0;

      issue(64'h3002, 0, 2, 0, 0, 0, 0);
      watch_a();
      chk("mis_n", 64'(misc), 1);
      chk("mis_cyc", 64'(cycc), 0);
      chk("mis_rwe", 64'(rwec), 0);

      issue(64'h55, 0, 3, 0, 1, 0, 0);
      watch_a();
      chk("nm_rdat", rdat_a, 64'h55);
      chk("nm_rwe", 64'(rwec), 1);
      chk("nm_busy", 64'(busyc), 0);
      chk("nm_cyc", 64'(cycc), 0);

      err_en = 1'b1; err_adr = 64'h1002;
      issue(64'h1000, 0, 3, 0, 0, 0, 0);
      watch_a();
      chk("er_beats", 64'(nb), 2);
      chk("er_adr1", adrs[1], 64'h1002);
      chk("er_cyc", 64'(cycc), 3);
      chk("er_fault", 64'(faultc), 1);
      chk("er_rwe", 64'(rwec), 0);
      chk("er_rdat", rdat_a, 64'h55);
      err_en = 1'b0;

      issue(64'h1000, 0, 3, 0, 0, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (cyc_a && !stb_a) found = 1'b1;
         else @(negedge clk);
      end
      chk("rw_wait", found, 1);
      rst_n = 1'b0;
      #1;
      chk("rw_cyc", cyc_a, 0);
      chk("rw_stb", stb_a, 0);
      chk("rw_busy", busy_a, 0);
      @(negedge clk);
      chk("rw_rwe", rwe_a, 0);
      chk("rw_rdat", rdat_a, 0);
      rst_n = 1'b1;
      issue(64'h1000, 0, 3, 0, 0, 0, 0);
      watch_a();
      chk("rw_next", rdat_a, 64'h9006_9004_9002_9000);
      chk("rw_rwe_n", 64'(rwec), 1);

      stall_req = 4'd2;
      issue(64'h2006, 1, 1, 0, 0, 64'hBEEF, 1);
      watch_b();
      chk("st_stb", 64'(stbc), 3);
      chk("st_sel", 64'(sel0), 64'hC);
      chk("st_dat", 64'(dat0), 64'hBEEF_0000);
      chk("st_adr", adrs[0], 64'h2004);
      chk("st_we", we0, 1);
      chk("st_rwe", 64'(rwec), 0);
      chk("st_idle", busy_b, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
